hazard_ctrl: RTL and testbench

//  Pipeline sequencer for the 5-stage core. Drives enable/flush of PC and buffers 1-4 (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/hazard_pkg.sv | 38 +++
 rtl/hazard_ctrl_fwd_sel.sv | 24 ++
 rtl/hazard_ctrl.sv | 137 +++++++++++++
 tb/tb_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard sequencer.
// Holds the FSM state, forwarding encodings and the stage-control bundle.
package hazard_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    FREEZE = 1'b1
  } state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_en;
    logic buf1_en;
    logic buf2_en;
    logic buf3_en;
    logic buf4_en;
    logic buf1_flush;
    logic buf2_flush;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;
  localparam ctrl_t CTRL_RUN  = '{pc_en: 1'b1, buf1_en: 1'b1, buf2_en: 1'b1,
                                  buf3_en: 1'b1, buf4_en: 1'b1,
                                  buf1_flush: 1'b0, buf2_flush: 1'b0};

  // A later stage can supply src only if it writes a real (non-zero) register.
  function automatic logic fwd_match(input logic       regwrite,
                                     input logic [4:0] aw,
                                     input logic [4:0] src);
    return regwrite && (aw != REG_ZERO) && (aw == src);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// EX operand bypass select for one source register.
// EX/MEM has priority over MEM/WB because it holds the younger result.
module fwd_sel
  import hazard_pkg::*;
(
  input  logic [4:0] src,
  input  logic       mem_regwrite,
  input  logic [4:0] mem_AW,
  input  logic       wb_regwrite,
  input  logic [4:0] wb_AW,
  output logic [1:0] sel
);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    sel = FWD_RF;
    if (fwd_match(mem_regwrite, mem_AW, src)) begin
      sel = FWD_MEM;
    end else if (fwd_match(wb_regwrite, wb_AW, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stage enables/flushes, operand forwarding,
// memory-wait freeze with sticky timeout, and saturating perf counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic             ex_regwrite,
  input  logic             ex_memtoreg,
  input  logic [4:0]       ex_AW,
  input  logic             mem_regwrite,
  input  logic [4:0]       mem_AW,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_AW,
  input  logic             ex_branch,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             buf1_en,
  output logic             buf2_en,
  output logic             buf3_en,
  output logic             buf4_en,
  output logic             buf1_flush,
  output logic             buf2_flush,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             mem_err
);

  localparam int              TMO_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q;
  ctrl_t            ctrl;
  logic             freeze;
  logic             load_use;
  logic             flush_evt;
  logic [1:0]       sel_a, sel_b;

  assign freeze   = mem_req && !mem_ready;
  assign load_use = ex_memtoreg && ex_regwrite && (ex_AW != REG_ZERO) &&
                    ((ex_AW == id_rs) || (id_uses_rt && (ex_AW == id_rt)));

  // State register, freeze timeout, sticky error and performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      tmo_q     <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
      mem_err   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q <= state_d;
      if (freeze) begin
        if (tmo_q != TMO_MAX) tmo_q <= tmo_q + 1'b1;
        if (tmo_q >= TMO_LAST) mem_err <= 1'b1;
      end else begin
        tmo_q <= '0;
      end
      if (!ctrl.pc_en && stall_cnt != CNT_SAT) stall_cnt <= stall_cnt + 1'b1;
      if (flush_evt && flush_cnt != CNT_SAT)   flush_cnt <= flush_cnt + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (freeze)  state_d = FREEZE;
      FREEZE:  if (!freeze) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Control decode: freeze dominates; otherwise branch flush beats load-use stall.
  // A FREEZE release cycle decodes exactly like RUN, so the held branch fires then.
  always_comb begin
    ctrl      = CTRL_RUN;
    flush_evt = 1'b0;
    if (!rst_n) begin
      ctrl = CTRL_IDLE;
    end else if (freeze) begin
      ctrl = CTRL_IDLE;
    end else if (ex_branch) begin
      ctrl.buf1_flush = 1'b1;
      ctrl.buf2_flush = 1'b1;
      flush_evt       = 1'b1;
    end else if (load_use) begin
      ctrl.pc_en      = 1'b0;
      ctrl.buf1_en    = 1'b0;
      ctrl.buf2_flush = 1'b1;
    end
  end

  assign pc_en      = ctrl.pc_en;
  assign buf1_en    = ctrl.buf1_en;
  assign buf2_en    = ctrl.buf2_en;
  assign buf3_en    = ctrl.buf3_en;
  assign buf4_en    = ctrl.buf4_en;
  assign buf1_flush = ctrl.buf1_flush;
  assign buf2_flush = ctrl.buf2_flush;

  fwd_sel u_fwd_a (
    .src          (ex_rs),
    .mem_regwrite (mem_regwrite),
    .mem_AW       (mem_AW),
    .wb_regwrite  (wb_regwrite),
    .wb_AW        (wb_AW),
    .sel          (sel_a)
  );

  fwd_sel u_fwd_b (
    .src          (ex_rt),
    .mem_regwrite (mem_regwrite),
    .mem_AW       (mem_AW),
    .wb_regwrite  (wb_regwrite),
    .wb_AW        (wb_AW),
    .sel          (sel_b)
  );

  assign fwd_a = rst_n ? sel_a : FWD_RF;
  assign fwd_b = rst_n ? sel_b : FWD_RF;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: stalls, flushes, freeze/timeout,
// forwarding, counter saturation and asynchronous reset.
module tb_hazard_ctrl;

  localparam int CNT_W = 4;
  localparam int MEM_TIMEOUT = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_AW, mem_AW, wb_AW;
  logic id_uses_rt, ex_regwrite, ex_memtoreg, mem_regwrite, wb_regwrite;
  logic ex_branch, mem_req, mem_ready;
  logic pc_en, buf1_en, buf2_en, buf3_en, buf4_en, buf1_flush, buf2_flush;
  logic [1:0] fwd_a, fwd_b;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;
  logic mem_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_regwrite(ex_regwrite),
    .ex_memtoreg(ex_memtoreg), .ex_AW(ex_AW),
    .mem_regwrite(mem_regwrite), .mem_AW(mem_AW),
    .wb_regwrite(wb_regwrite), .wb_AW(wb_AW),
    .ex_branch(ex_branch), .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .buf1_en(buf1_en), .buf2_en(buf2_en), .buf3_en(buf3_en),
    .buf4_en(buf4_en), .buf1_flush(buf1_flush), .buf2_flush(buf2_flush),
    .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_err(mem_err)
  );

  // Packed view of {pc_en, buf1_en..buf4_en, buf1_flush, buf2_flush}.
  wire [6:0] ctl = {pc_en, buf1_en, buf2_en, buf3_en, buf4_en, buf1_flush, buf2_flush};
  localparam logic [6:0] C_RUN   = 7'b11111_00;
  localparam logic [6:0] C_ZERO  = 7'b00000_00;
  localparam logic [6:0] C_BR    = 7'b11111_11;
  localparam logic [6:0] C_STALL = 7'b00111_01;

  task automatic idle_inputs();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_rs = 5'd3; ex_rt = 5'd4; ex_regwrite = 1'b0; ex_memtoreg = 1'b0; ex_AW = 5'd0;
    mem_regwrite = 1'b0; mem_AW = 5'd0; wb_regwrite = 1'b0; wb_AW = 5'd0;
    ex_branch = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
  endtask

  task automatic set_load_use(input logic [4:0] aw);
    ex_memtoreg = 1'b1; ex_regwrite = 1'b1; ex_AW = aw;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #2;
    checks++; if (ctl !== C_ZERO) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_ZERO); end
    apply_reset();
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0 || mem_err !== 1'b0) begin
      failures++; $display("FAIL reset_state stall=%0d flush=%0d err=%b exp 0/0/0", stall_cnt, flush_cnt, mem_err);
    end
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL reset_run_ctl got=%b exp=%b", ctl, C_RUN); end
  endtask

  task automatic test_load_use();
    apply_reset();
    set_load_use(5'd5); id_rs = 5'd5;
    #1;
    checks++; if (ctl !== C_STALL) begin failures++; $display("FAIL lu_rs_ctl got=%b exp=%b", ctl, C_STALL); end
    tick();
    ex_memtoreg = 1'b0; ex_regwrite = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL lu_one_bubble ctl=%b stall=%0d exp=%b/1", ctl, stall_cnt, C_RUN);
    end
    // Non-hazard variants, all inside one cycle.
    set_load_use(5'd5); id_rs = 5'd3; id_rt = 5'd5; id_uses_rt = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL lu_rt_unused got=%b exp=%b", ctl, C_RUN); end
    ex_AW = 5'd0; id_rs = 5'd0;
    #1;
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL lu_reg0 got=%b exp=%b", ctl, C_RUN); end
    ex_AW = 5'd5; id_rs = 5'd5; ex_memtoreg = 1'b0;
    #1;
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL lu_not_load got=%b exp=%b", ctl, C_RUN); end
    ex_memtoreg = 1'b1; id_rs = 5'd3; id_uses_rt = 1'b1;
    #1;
    checks++; if (ctl !== C_STALL) begin failures++; $display("FAIL lu_rt_ctl got=%b exp=%b", ctl, C_STALL); end
    tick();
    idle_inputs();
    #1;
    checks++; if (stall_cnt !== 4'd2) begin failures++; $display("FAIL lu_stall_cnt got=%0d exp=2", stall_cnt); end
  endtask

  task automatic test_branch();
    apply_reset();
    set_load_use(5'd5); id_rs = 5'd5; ex_branch = 1'b1;
    #1;
    checks++; if (ctl !== C_BR) begin failures++; $display("FAIL br_ctl got=%b exp=%b", ctl, C_BR); end
    tick();
    idle_inputs();
    #1;
    checks++; if (flush_cnt !== 4'd1 || stall_cnt !== 4'd0) begin
      failures++; $display("FAIL br_cnt flush=%0d stall=%0d exp=1/0", flush_cnt, stall_cnt);
    end
  endtask

  task automatic test_freeze();
    apply_reset();
    mem_req = 1'b1; mem_ready = 1'b0; ex_branch = 1'b1;
    set_load_use(5'd5); id_rs = 5'd5;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (ctl !== C_ZERO) begin failures++; $display("FAIL frz_ctl cyc=%0d got=%b exp=%b", i, ctl, C_ZERO); end
      tick();
    end
    checks++; if (stall_cnt !== 4'd3 || flush_cnt !== 4'd0) begin
      failures++; $display("FAIL frz_cnt stall=%0d flush=%0d exp=3/0", stall_cnt, flush_cnt);
    end
    mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_BR) begin failures++; $display("FAIL frz_release_br got=%b exp=%b", ctl, C_BR); end
    tick();
    idle_inputs();
    #1;
    checks++; if (ctl !== C_RUN || flush_cnt !== 4'd1 || stall_cnt !== 4'd3) begin
      failures++; $display("FAIL frz_after ctl=%b flush=%0d stall=%0d exp=%b/1/3", ctl, flush_cnt, stall_cnt, C_RUN);
    end
    // Load-use held across a freeze is suppressed, then stalls on release.
    mem_req = 1'b1; set_load_use(5'd6); id_rt = 5'd6; id_uses_rt = 1'b1;
    #1;
    checks++; if (ctl !== C_ZERO) begin failures++; $display("FAIL frz_lu_supp got=%b exp=%b", ctl, C_ZERO); end
    tick();
    mem_ready = 1'b1;
    #1;
    checks++; if (ctl !== C_STALL) begin failures++; $display("FAIL frz_lu_release got=%b exp=%b", ctl, C_STALL); end
    tick();
    idle_inputs();
    #1;
    checks++; if (stall_cnt !== 4'd5) begin failures++; $display("FAIL frz_lu_cnt got=%0d exp=5", stall_cnt); end
  endtask

  task automatic test_timeout();
    apply_reset();
    mem_req = 1'b1;
    repeat (3) tick();
    mem_ready = 1'b1;   // one release cycle clears the timeout
    tick();
    mem_ready = 1'b0;
    repeat (3) tick();
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL tmo_before got=%b exp=0", mem_err); end
    tick();
    checks++; if (mem_err !== 1'b1) begin failures++; $display("FAIL tmo_set got=%b exp=1", mem_err); end
    checks++; if (ctl !== C_ZERO) begin failures++; $display("FAIL tmo_still_frozen got=%b exp=%b", ctl, C_ZERO); end
    repeat (2) tick();
    checks++; if (stall_cnt !== 4'd9) begin failures++; $display("FAIL tmo_stall got=%0d exp=9", stall_cnt); end
    repeat (6) tick();
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL stall_sat got=%0d exp=15", stall_cnt); end
    repeat (2) tick();
    checks++; if (stall_cnt !== 4'd15) begin failures++; $display("FAIL stall_hold got=%0d exp=15", stall_cnt); end
    mem_ready = 1'b1;
    tick();
    checks++; if (mem_err !== 1'b1 || ctl !== C_RUN) begin
      failures++; $display("FAIL tmo_sticky err=%b ctl=%b exp=1/%b", mem_err, ctl, C_RUN);
    end
  endtask

  task automatic test_flush_saturation();
    apply_reset();
    ex_branch = 1'b1;
    repeat (15) tick();
    checks++; if (flush_cnt !== 4'd15) begin failures++; $display("FAIL flush_sat got=%0d exp=15", flush_cnt); end
    tick();
    checks++; if (flush_cnt !== 4'd15) begin failures++; $display("FAIL flush_hold got=%0d exp=15", flush_cnt); end
    idle_inputs();
  endtask

  task automatic test_forwarding();
    apply_reset();
    mem_AW = 5'd7; wb_AW = 5'd7; mem_regwrite = 1'b1; wb_regwrite = 1'b1;
    ex_rs = 5'd7; ex_rt = 5'd3;
    #1;
    checks++; if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
      failures++; $display("FAIL fwd_mem a=%b b=%b exp=10/00", fwd_a, fwd_b);
    end
    mem_regwrite = 1'b0;
    #1;
    checks++; if (fwd_a !== 2'b01) begin failures++; $display("FAIL fwd_wb got=%b exp=01", fwd_a); end
    mem_regwrite = 1'b1; mem_AW = 5'd0; wb_AW = 5'd0; ex_rs = 5'd0;
    #1;
    checks++; if (fwd_a !== 2'b00) begin failures++; $display("FAIL fwd_reg0 got=%b exp=00", fwd_a); end
    mem_AW = 5'd9; wb_AW = 5'd9; ex_rt = 5'd9; ex_rs = 5'd2;
    #1;
    checks++; if (fwd_b !== 2'b10 || fwd_a !== 2'b00) begin
      failures++; $display("FAIL fwd_b_mem a=%b b=%b exp=00/10", fwd_a, fwd_b);
    end
    mem_AW = 5'd8;
    #1;
    checks++; if (fwd_b !== 2'b01) begin failures++; $display("FAIL fwd_b_wb got=%b exp=01", fwd_b); end
    idle_inputs();
  endtask

  task automatic test_reset_mid_freeze();
    apply_reset();
    ex_branch = 1'b1;
    tick();
    ex_branch = 1'b0; mem_req = 1'b1;
    repeat (5) tick();
    checks++; if (mem_err !== 1'b1 || stall_cnt !== 4'd5 || flush_cnt !== 4'd1) begin
      failures++; $display("FAIL rmf_setup err=%b stall=%0d flush=%0d exp=1/5/1", mem_err, stall_cnt, flush_cnt);
    end
    mem_AW = 5'd7; mem_regwrite = 1'b1; ex_rs = 5'd7;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (ctl !== C_ZERO || fwd_a !== 2'b00) begin
      failures++; $display("FAIL rmf_ctl ctl=%b fwd_a=%b exp=%b/00", ctl, fwd_a, C_ZERO);
    end
    checks++; if (mem_err !== 1'b0 || stall_cnt !== 0 || flush_cnt !== 0) begin
      failures++; $display("FAIL rmf_clear err=%b stall=%0d flush=%0d exp=0/0/0", mem_err, stall_cnt, flush_cnt);
    end
    tick();
    checks++; if (stall_cnt !== 0 || ctl !== C_ZERO) begin
      failures++; $display("FAIL rmf_held stall=%0d ctl=%b exp=0/%b", stall_cnt, ctl, C_ZERO);
    end
    idle_inputs();
    rst_n = 1'b1;
    #1;
    checks++; if (ctl !== C_RUN) begin failures++; $display("FAIL rmf_run got=%b exp=%b", ctl, C_RUN); end
    mem_req = 1'b1;
    repeat (3) tick();
    checks++; if (mem_err !== 1'b0) begin failures++; $display("FAIL rmf_tmo_cleared got=%b exp=0", mem_err); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_freeze();
    test_timeout();
    test_flush_saturation();
    test_forwarding();
    test_reset_mid_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
